// File: rtl/demux1_4_stream_if.sv
// Stream bundle for demux1_4_stream: one producer channel in, four consumer channels out.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface demux1_4_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, busy
    );
endinterface

// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 stream demultiplexer with per-channel holding registers and burst route locking.
// Optional feature: define DEMUX_CNT_EN to add per-channel 8-bit handshake counters on cnt_flat.
module demux1_4_stream #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    demux1_4_stream_if.slave bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [31:0] cnt_flat
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       burst_sel_r;
    logic [1:0]       burst_sel_s;
    logic [1:0]       dst_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       valid_r;
    logic [3:0]       valid_s;
    logic [3:0]       load_s;
    logic [WIDTH-1:0] data_r [4];

    // Destination: free choice while idle, locked route during a burst.
    always_comb begin
        dst_s = bus.in_sel;
        if (state_r == ST_BURST) begin
            dst_s = burst_sel_r;
        end else begin
            dst_s = bus.in_sel;
        end
    end

    // A full channel still accepts when its consumer drains in the same cycle.
    assign in_ready_s = ~valid_r[dst_s] | bus.out_ready[dst_s];
    assign accept_s   = bus.in_valid & in_ready_s;

    // Per-channel load strobes and next valid flags.
    always_comb begin
        load_s  = 4'b0000;
        valid_s = valid_r;
        for (int c = 0; c < 4; c++) begin
            load_s[c]  = accept_s & (dst_s == c[1:0]);
            valid_s[c] = load_s[c] | (valid_r[c] & ~bus.out_ready[c]);
        end
    end

    // Burst FSM next-state logic.
    always_comb begin
        state_s     = state_r;
        burst_sel_s = burst_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !bus.in_last) begin
                    state_s     = ST_BURST;
                    burst_sel_s = bus.in_sel;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (accept_s && bus.in_last) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                burst_sel_s = 2'd0;
            end
        endcase
    end

    // FSM state, route latch and valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            burst_sel_r <= 2'd0;
            valid_r     <= 4'b0000;
        end else begin
            state_r     <= state_s;
            burst_sel_r <= burst_sel_s;
            valid_r     <= valid_s;
        end
    end

    // Channel holding registers; data is kept when not loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                data_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (load_s[c]) begin
                    data_r[c] <= bus.in_data;
                end
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_r [4];

    // Output handshake counters, wrapping at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                cnt_r[c] <= 8'd0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (valid_r[c] && bus.out_ready[c]) begin
                    cnt_r[c] <= cnt_r[c] + 8'd1;
                end
            end
        end
    end

    assign cnt_flat = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out0_data = data_r[0];
    assign bus.out1_data = data_r[1];
    assign bus.out2_data = data_r[2];
    assign bus.out3_data = data_r[3];
    assign bus.out_valid = valid_r;
    assign bus.busy      = (state_r == ST_BURST);

endmodule

// File: tb/tb_demux1_4_stream.sv
// Directed self-checking bench for demux1_4_stream with hand-computed expectations.
module tb_demux1_4_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux1_4_stream_if #(.WIDTH(8)) bus ();

`ifdef DEMUX_CNT_EN
    logic [31:0] cnt_flat;
`endif

    demux1_4_stream #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_flat (cnt_flat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present a beat, wait (bounded) for acceptance, leave time at posedge+1.
    task automatic send_beat(input logic [7:0] d, input logic [1:0] s, input logic l);
        bit done;
        done         = 1'b0;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            check_eq("send_timeout", 32'h0, 32'h1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sel   = 2'd0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check_eq("rst_data", {bus.out3_data, bus.out2_data, bus.out1_data, bus.out0_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single beat to channel 2
        send_beat(8'hA5, 2'd2, 1'b1);
        check_eq("single_data", 32'(bus.out2_data), 32'hA5);
        check_eq("single_valid", 32'(bus.out_valid), 32'h4);
        check_eq("single_busy", 32'(bus.busy), 32'h0);
        cycle();
        check_eq("single_drained", 32'(bus.out_valid), 32'h0);

        // Burst locked to channel 1 despite in_sel changes
        send_beat(8'h11, 2'd1, 1'b0);
        check_eq("burst1_data", 32'(bus.out1_data), 32'h11);
        check_eq("burst1_busy", 32'(bus.busy), 32'h1);
        send_beat(8'h22, 2'd3, 1'b0);
        check_eq("burst2_data", 32'(bus.out1_data), 32'h22);
        check_eq("burst2_valid", 32'(bus.out_valid), 32'h2);
        check_eq("burst2_out3", 32'(bus.out3_data), 32'h0);
        check_eq("burst2_busy", 32'(bus.busy), 32'h1);
        send_beat(8'h33, 2'd0, 1'b1);
        check_eq("burst3_data", 32'(bus.out1_data), 32'h33);
        check_eq("burst3_out0", 32'(bus.out0_data), 32'h0);
        check_eq("burst3_busy", 32'(bus.busy), 32'h0);
        cycle();

        // Stall on channel 0
        bus.out_ready = 4'b1110;
        send_beat(8'h44, 2'd0, 1'b1);
        check_eq("stall_first", 32'(bus.out0_data), 32'h44);
        check_eq("stall_valid", 32'(bus.out_valid), 32'h1);
        bus.in_sel = 2'd0;
        #1;
        check_eq("stall_rdy_novalid", 32'(bus.in_ready), 32'h0);
        bus.in_data  = 8'h55;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check_eq("stall_rdy", 32'(bus.in_ready), 32'h0);
        cycle();
        check_eq("stall_hold", 32'(bus.out0_data), 32'h44);
        bus.out_ready = 4'b1111;
        #1;
        check_eq("release_rdy", 32'(bus.in_ready), 32'h1);
        cycle();
        bus.in_valid = 1'b0;
        check_eq("release_data", 32'(bus.out0_data), 32'h55);
        check_eq("release_valid", 32'(bus.out_valid), 32'h1);
        cycle();
        check_eq("release_drained", 32'(bus.out_valid), 32'h0);

        // Independence: channel 0 stalled and full, channel 3 still open
        bus.out_ready = 4'b1110;
        send_beat(8'h66, 2'd0, 1'b1);
        send_beat(8'h77, 2'd3, 1'b1);
        check_eq("indep_valid", 32'(bus.out_valid), 32'h9);
        check_eq("indep_out3", 32'(bus.out3_data), 32'h77);
        check_eq("indep_out0", 32'(bus.out0_data), 32'h66);
        bus.out_ready = 4'b1111;
        repeat (2) cycle();

        // Reset mid-burst
        bus.out_ready = 4'b0010;
        send_beat(8'h81, 2'd1, 1'b0);
        send_beat(8'h82, 2'd1, 1'b0);
        check_eq("mid_busy_pre", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_valid", 32'(bus.out_valid), 32'h0);
        check_eq("mid_busy", 32'(bus.busy), 32'h0);
        check_eq("mid_data", 32'(bus.out1_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        send_beat(8'h90, 2'd2, 1'b1);
        check_eq("post_rst_data", 32'(bus.out2_data), 32'h90);
        check_eq("post_rst_valid", 32'(bus.out_valid), 32'h4);

`ifdef DEMUX_CNT_EN
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 4'b1111;
        cycle();
        for (int k = 0; k < 257; k++) begin
            send_beat(8'(k), 2'd1, 1'b1);
        end
        cycle();
        check_eq("cnt_wrap", cnt_flat, 32'h0000_0100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
